// File: rtl/expo_host_ctrl_pkg.sv
// expo_host_ctrl shared types: FSM states, operand slots, bus defaults.
// TOUT exists only when EXPO_TIMEOUT_EN is defined.
package expo_host_ctrl_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int OP_W_DEF   = 512;

  localparam logic [2:0] OP_X  = 3'd0;
  localparam logic [2:0] OP_M  = 3'd1;
  localparam logic [2:0] OP_E  = 3'd2;
  localparam logic [2:0] OP_R  = 3'd3;
  localparam logic [2:0] OP_R2 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    UNLOAD
`ifdef EXPO_TIMEOUT_EN
    ,
    TOUT
`endif
  } state_e;

endpackage

// File: rtl/expo_host_ctrl_if.sv
// Host word streams: inbound operand words (s_*), outbound result words (m_*).
// The controller takes the slave view, the host the master view.
interface expo_host_ctrl_if
  import expo_host_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

endinterface

// File: rtl/expo_word_serializer.sv
// Captures a wide result and streams it out LSW first on a valid/ready port.
// The shift register doubles as the result register.
module expo_word_serializer #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [WORD_W*NWORDS-1:0] load_data,
  input  logic                     m_ready,
  output logic [WORD_W-1:0]        m_data,
  output logic                     m_valid,
  output logic                     m_last,
  output logic                     last_xfer
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  logic [WORD_W*NWORDS-1:0] sh_q, sh_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     vld_q, vld_d;
  logic                     xfer;

  assign xfer      = vld_q & m_ready;
  assign m_data    = sh_q[WORD_W-1:0];
  assign m_valid   = vld_q;
  assign m_last    = vld_q & (cnt_q == LAST);
  assign last_xfer = xfer & m_last;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (load) begin
      sh_d  = load_data;
      cnt_d = '0;
      vld_d = 1'b1;
    end else if (xfer) begin
      sh_d = sh_q >> WORD_W;
      if (m_last) begin
        cnt_d = '0;
        vld_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/expo_host_ctrl.sv
// Host-side controller for the modular exponentiation core.
// Define EXPO_TIMEOUT_EN to add a 20-bit WAIT watchdog with an err pulse.
module expo_host_ctrl
  import expo_host_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int NWORDS = OP_W / WORD_W
) (
  input  logic                clk,
  input  logic                resetn,
  expo_host_ctrl_if.slave     bus,
  output logic                startExponentiation,
  output logic                multiplication_enable,
  input  logic                done,
  input  logic [OP_W-1:0]     A_result,
  output logic [OP_W-1:0]     x,
  output logic [OP_W-1:0]     modulus,
  output logic [OP_W-1:0]     exponent,
  output logic [OP_W-1:0]     Rmodm,
  output logic [OP_W-1:0]     Rsquaredmodm,
  output logic                busy,
  output logic                err
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  state_e          st_q, st_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   wc_q, wc_d;
  logic            men_q, men_d;
  logic [OP_W-1:0] x_q, x_d, m_q, m_d, e_q, e_d;
  logic [OP_W-1:0] r_q, r_d, r2_q, r2_d;
  logic            s_rdy, s_acc, ld_last;
  logic            ser_load, ser_last;
`ifdef EXPO_TIMEOUT_EN
  logic [19:0]     wd_q, wd_d;
`endif

  assign s_rdy   = (st_q == IDLE) | (st_q == LOAD);
  assign s_acc   = s_rdy & bus.s_valid;
  assign ld_last = (op_q == OP_R2) & (wc_q == LAST);

  assign bus.s_ready           = s_rdy;
  assign startExponentiation   = (st_q == START) | (st_q == WAIT);
  assign multiplication_enable = men_q;
  assign busy                  = (st_q != IDLE);
  assign x                     = x_q;
  assign modulus               = m_q;
  assign exponent              = e_q;
  assign Rmodm                 = r_q;
  assign Rsquaredmodm          = r2_q;
`ifdef EXPO_TIMEOUT_EN
  assign err = (st_q == TOUT);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    op_d     = op_q;
    wc_d     = wc_q;
    men_d    = men_q;
    x_d      = x_q;
    m_d      = m_q;
    e_d      = e_q;
    r_d      = r_q;
    r2_d     = r2_q;
    ser_load = 1'b0;
`ifdef EXPO_TIMEOUT_EN
    wd_d     = wd_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (s_acc) begin
          men_d = bus.s_data[0];
          st_d  = LOAD;
        end
      end
      LOAD: begin
        if (s_acc) begin
          unique case (op_q)
            OP_X:    x_d[wc_q*WORD_W +: WORD_W]  = bus.s_data;
            OP_M:    m_d[wc_q*WORD_W +: WORD_W]  = bus.s_data;
            OP_E:    e_d[wc_q*WORD_W +: WORD_W]  = bus.s_data;
            OP_R:    r_d[wc_q*WORD_W +: WORD_W]  = bus.s_data;
            OP_R2:   r2_d[wc_q*WORD_W +: WORD_W] = bus.s_data;
            default: ;
          endcase
          if (wc_q == LAST) begin
            wc_d = '0;
            op_d = ld_last ? 3'd0 : op_q + 3'd1;
          end else begin
            wc_d = wc_q + CW'(1);
          end
          if (ld_last) st_d = START;
        end
      end
      START: begin
        st_d = WAIT;
`ifdef EXPO_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      WAIT: begin
        if (done) begin
          ser_load = 1'b1;
          st_d     = UNLOAD;
        end
`ifdef EXPO_TIMEOUT_EN
        else if (wd_q == '1) st_d = TOUT;
        else wd_d = wd_q + 20'd1;
`endif
      end
      UNLOAD: begin
        if (ser_last) st_d = IDLE;
      end
`ifdef EXPO_TIMEOUT_EN
      TOUT: st_d = IDLE;
`endif
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q  <= IDLE;
      op_q  <= '0;
      wc_q  <= '0;
      men_q <= 1'b0;
      x_q   <= '0;
      m_q   <= '0;
      e_q   <= '0;
      r_q   <= '0;
      r2_q  <= '0;
`ifdef EXPO_TIMEOUT_EN
      wd_q  <= '0;
`endif
    end else begin
      st_q  <= st_d;
      op_q  <= op_d;
      wc_q  <= wc_d;
      men_q <= men_d;
      x_q   <= x_d;
      m_q   <= m_d;
      e_q   <= e_d;
      r_q   <= r_d;
      r2_q  <= r2_d;
`ifdef EXPO_TIMEOUT_EN
      wd_q  <= wd_d;
`endif
    end
  end

  expo_word_serializer #(
    .WORD_W (WORD_W),
    .NWORDS (NWORDS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (resetn),
    .load      (ser_load),
    .load_data (A_result),
    .m_ready   (bus.m_ready),
    .m_data    (bus.m_data),
    .m_valid   (bus.m_valid),
    .m_last    (bus.m_last),
    .last_xfer (ser_last)
  );

endmodule

// File: tb/tb_expo_host_ctrl.sv
// Directed bench for expo_host_ctrl with a behavioural core stub.
// Covers load/start/unload, backpressure, spurious done, reset, back-to-back.
module tb_expo_host_ctrl;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start, men, done, busy, err;
  logic [511:0] a_res;
  logic [511:0] x, modulus, exponent, rm, r2;
  logic [511:0] dut_ops [5];

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;
  logic start_prev = 1'b0;

  logic [31:0] got_w [16];
  bit          got_l [16];
  int          n_got;
  logic [31:0] stall_seen [5];
  int          stall_n;
  bit          sr_unl;

  expo_host_ctrl_if #(.WORD_W(32)) bus();

  expo_host_ctrl dut (
    .clk                   (clk),
    .resetn                (resetn),
    .bus                   (bus),
    .startExponentiation   (start),
    .multiplication_enable (men),
    .done                  (done),
    .A_result              (a_res),
    .x                     (x),
    .modulus               (modulus),
    .exponent              (exponent),
    .Rmodm                 (rm),
    .Rsquaredmodm          (r2),
    .busy                  (busy),
    .err                   (err)
  );

  assign dut_ops[0] = x;
  assign dut_ops[1] = modulus;
  assign dut_ops[2] = exponent;
  assign dut_ops[3] = rm;
  assign dut_ops[4] = r2;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start && !start_prev) n_starts = n_starts + 1;
    start_prev = start;
  end

  function automatic logic [31:0] opw(input int o, input int k,
                                      input logic [31:0] seed);
    return seed ^ (32'h9E3779B9 * 32'(o * 16 + k + 1));
  endfunction

  function automatic logic [511:0] opv(input int o, input logic [31:0] seed);
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = opw(o, k, seed);
    return v;
  endfunction

  task automatic send_job(input logic [31:0] hdr, input logic [31:0] seed,
                          input bit gaps, input bit skip_hdr,
                          input int abort_at, input int spur_at,
                          output int n_sent, output bit early_start);
    bit acc;
    n_sent = 0;
    early_start = 0;
    for (int i = (skip_hdr ? 1 : 0); i <= 80; i++) begin
      if (abort_at > 0 && i == abort_at + 1) break;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.s_valid = 1'b0;
          if (start) early_start = 1;
          @(posedge clk); #1;
        end
      end
      bus.s_data  = (i == 0) ? hdr : opw((i - 1) / 16, (i - 1) % 16, seed);
      bus.s_valid = 1'b1;
      if (i == spur_at) begin
        done  = 1'b1;
        a_res = {16{32'hDEADBEEF}};
      end
      acc = 0;
      for (int c = 0; c < 20 && !acc; c++) begin
        if (start) early_start = 1;
        acc = bus.s_ready;
        @(posedge clk); #1;
        done = 1'b0;
      end
      bus.s_valid = 1'b0;
      if (acc) n_sent++;
      else break;
    end
  endtask

  task automatic run_core(input logic [511:0] res, input int lat,
                          output bit seen, output bit held,
                          output bit sr_low, output bit dropped);
    seen = 0;
    held = 1;
    sr_low = 1;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (start) seen = 1;
      else begin @(posedge clk); #1; end
    end
    repeat (lat) begin
      @(posedge clk); #1;
      if (!start) held = 0;
      if (bus.s_ready) sr_low = 0;
    end
    done  = 1'b1;
    a_res = res;
    @(posedge clk); #1;
    done = 1'b0;
    dropped = !start;
  endtask

  task automatic recv(input int stall_idx);
    bit xfer;
    logic [31:0] d;
    bit l;
    n_got = 0;
    stall_n = 0;
    sr_unl = 0;
    for (int c = 0; c < 200 && n_got < 16; c++) begin
      if (n_got == stall_idx && stall_n < 5 && bus.m_valid) begin
        bus.m_ready = 1'b0;
        stall_seen[stall_n] = bus.m_data;
        stall_n++;
      end else begin
        bus.m_ready = 1'b1;
      end
      if (bus.m_valid && bus.s_ready) sr_unl = 1;
      xfer = bus.m_valid && bus.m_ready;
      d = bus.m_data;
      l = bus.m_last;
      @(posedge clk); #1;
      if (xfer) begin
        got_w[n_got] = d;
        got_l[n_got] = l;
        n_got++;
      end
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b want 0", start); end
    n_tests++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_mvalid got %b/%b want 0/0", bus.m_valid, bus.m_last);
    end
    n_tests++;
    if (men !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL rst_men_err got %b/%b want 0/0", men, err);
    end
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_sready got %b want 1", bus.s_ready); end
    n_tests++;
    if (x !== '0 || r2 !== '0) begin n_fail++; $display("FAIL rst_ops got %h want 0", x); end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector1;
    logic [511:0] res;
    int ns, s0;
    bit es, seen, held, srl, drp;
    res = opv(7, 32'h1234);
    res[31:0] = 32'h5f22cdec;
    res[511:480] = 32'h5764fd96;
    s0 = n_starts;
    send_job(32'h1, 32'h0, 0, 0, 0, -1, ns, es);
    n_tests++;
    if (ns !== 81) begin n_fail++; $display("FAIL v1_sent got %0d want 81", ns); end
    n_tests++;
    if (es !== 1'b0) begin n_fail++; $display("FAIL v1_early_start got %b want 0", es); end
    n_tests++;
    if (men !== 1'b1) begin n_fail++; $display("FAIL v1_men got %b want 1", men); end
    for (int o = 0; o < 5; o++) begin
      n_tests++;
      if (dut_ops[o] !== opv(o, 32'h0)) begin
        n_fail++; $display("FAIL v1_op%0d got %h want %h", o, dut_ops[o], opv(o, 32'h0));
      end
    end
    run_core(res, 4, seen, held, srl, drp);
    n_tests++;
    if ({seen, held, srl, drp} !== 4'b1111) begin
      n_fail++; $display("FAIL v1_core seen/held/sready_low/dropped got %b want 1111",
                         {seen, held, srl, drp});
    end
    recv(-1);
    n_tests++;
    if (n_got !== 16) begin n_fail++; $display("FAIL v1_nwords got %0d want 16", n_got); end
    n_tests++;
    if (got_w[0] !== 32'h5f22cdec) begin
      n_fail++; $display("FAIL v1_word0 got %h want 5f22cdec", got_w[0]);
    end
    n_tests++;
    if (got_w[15] !== 32'h5764fd96 || got_l[15] !== 1'b1) begin
      n_fail++; $display("FAIL v1_word15 got %h/%b want 5764fd96/1", got_w[15], got_l[15]);
    end
    for (int k = 0; k < 15; k++) begin
      n_tests++;
      if (got_w[k] !== res[k*32 +: 32] || got_l[k] !== 1'b0) begin
        n_fail++; $display("FAIL v1_w%0d got %h/%b want %h/0", k, got_w[k], got_l[k], res[k*32 +: 32]);
      end
    end
    n_tests++;
    if (n_starts - s0 !== 1) begin n_fail++; $display("FAIL v1_starts got %0d want 1", n_starts - s0); end
    n_tests++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL v1_idle busy/mvalid got %b/%b want 0/0", busy, bus.m_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [511:0] res;
    int ns;
    bit es, seen, held, srl, drp;
    res = opv(6, 32'hA5A5_0F0F);
    send_job(32'hFFFF_FFFE, 32'h5555_AAAA, 1, 0, 0, -1, ns, es);
    n_tests++;
    if (men !== 1'b0) begin n_fail++; $display("FAIL bp_men got %b want 0", men); end
    for (int o = 0; o < 5; o++) begin
      n_tests++;
      if (dut_ops[o] !== opv(o, 32'h5555_AAAA)) begin
        n_fail++; $display("FAIL bp_op%0d got %h want %h", o, dut_ops[o], opv(o, 32'h5555_AAAA));
      end
    end
    run_core(res, 2, seen, held, srl, drp);
    recv(7);
    n_tests++;
    if (stall_n !== 5) begin n_fail++; $display("FAIL bp_stall_cycles got %0d want 5", stall_n); end
    for (int s = 0; s < 5; s++) begin
      n_tests++;
      if (stall_seen[s] !== res[7*32 +: 32]) begin
        n_fail++; $display("FAIL bp_hold%0d got %h want %h", s, stall_seen[s], res[7*32 +: 32]);
      end
    end
    n_tests++;
    if (n_got !== 16) begin n_fail++; $display("FAIL bp_nwords got %0d want 16", n_got); end
    for (int k = 0; k < 16; k++) begin
      n_tests++;
      if (got_w[k] !== res[k*32 +: 32]) begin
        n_fail++; $display("FAIL bp_w%0d got %h want %h", k, got_w[k], res[k*32 +: 32]);
      end
    end
  endtask

  task automatic test_spurious_done;
    logic [511:0] res;
    int ns, s0;
    bit es, seen, held, srl, drp;
    res = opv(5, 32'h0BAD_F00D);
    s0 = n_starts;
    send_job(32'h1, 32'h3333_0000, 0, 0, 0, 10, ns, es);
    n_tests++;
    if (ns !== 81 || es !== 1'b0) begin
      n_fail++; $display("FAIL sp_load sent/early got %0d/%b want 81/0", ns, es);
    end
    n_tests++;
    if (start !== 1'b1 || bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL sp_start start/mvalid got %b/%b want 1/0", start, bus.m_valid);
    end
    run_core(res, 1, seen, held, srl, drp);
    recv(-1);
    n_tests++;
    if (got_w[0] !== res[31:0] || got_w[9] !== res[9*32 +: 32]) begin
      n_fail++; $display("FAIL sp_result got %h want %h", got_w[0], res[31:0]);
    end
    n_tests++;
    if (n_starts - s0 !== 1) begin n_fail++; $display("FAIL sp_starts got %0d want 1", n_starts - s0); end
  endtask

  task automatic test_reset_midload;
    logic [511:0] res;
    int ns;
    bit es, seen, held, srl, drp;
    res = opv(4, 32'h7777_1111);
    send_job(32'h1, 32'h4444_4444, 0, 0, 40, -1, ns, es);
    n_tests++;
    if (ns !== 41) begin n_fail++; $display("FAIL rl_sent got %0d want 41", ns); end
    resetn = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || men !== 1'b0) begin
      n_fail++; $display("FAIL rl_async busy/men got %b/%b want 0/0", busy, men);
    end
    n_tests++;
    if (x !== '0 || modulus !== '0) begin
      n_fail++; $display("FAIL rl_ops got %h want 0", modulus);
    end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.m_valid !== 1'b0 || start !== 1'b0) begin
      n_fail++; $display("FAIL rl_nopartial mvalid/start got %b/%b want 0/0", bus.m_valid, start);
    end
    send_job(32'h0, 32'h2222_9999, 0, 0, 0, -1, ns, es);
    n_tests++;
    if (ns !== 81 || exponent !== opv(2, 32'h2222_9999)) begin
      n_fail++; $display("FAIL rl_fresh_load sent %0d exp %h", ns, exponent);
    end
    run_core(res, 3, seen, held, srl, drp);
    recv(-1);
    n_tests++;
    if (n_got !== 16 || got_w[15] !== res[511:480] || got_l[15] !== 1'b1) begin
      n_fail++; $display("FAIL rl_fresh_out got %0d words w15 %h want 16 %h", n_got, got_w[15], res[511:480]);
    end
  endtask

  task automatic test_back_to_back;
    logic [511:0] res;
    int ns;
    bit es, seen, held, srl, drp;
    res = opv(3, 32'hC0DE_0001);
    send_job(32'h0, 32'h6666_0000, 0, 0, 0, -1, ns, es);
    run_core(res, 2, seen, held, srl, drp);
    bus.s_data  = 32'h1;
    bus.s_valid = 1'b1;
    recv(-1);
    n_tests++;
    if (sr_unl !== 1'b0) begin n_fail++; $display("FAIL b2b_sready_unload got %b want 0", sr_unl); end
    n_tests++;
    if (busy !== 1'b0 || men !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle busy/men got %b/%b want 0/0", busy, men);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || men !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hdr busy/men got %b/%b want 1/1", busy, men);
    end
    send_job(32'h0, 32'h6666_1111, 0, 1, 0, -1, ns, es);
    n_tests++;
    if (ns !== 80 || r2 !== opv(4, 32'h6666_1111)) begin
      n_fail++; $display("FAIL b2b_load sent %0d r2 %h", ns, r2);
    end
    run_core(~res, 2, seen, held, srl, drp);
    recv(-1);
    n_tests++;
    if (n_got !== 16 || got_w[3] !== ~res[3*32 +: 32]) begin
      n_fail++; $display("FAIL b2b_out got %0d words w3 %h want 16 %h", n_got, got_w[3], ~res[3*32 +: 32]);
    end
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    done  = 1'b0;
    a_res = '0;
    test_reset();
    test_vector1();
    test_backpressure();
    test_spurious_done();
    test_reset_midload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
